// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the layer control path.
//   - command opcodes and their payload lengths
//   - FSM state encoding
//   - overlay-mode encodings
//   - layer count limit
package pipeline_ctrl_pkg;

  localparam int unsigned MAX_LAYERS = 16;
  localparam int unsigned NUM_FIELDS = 10;  // opcodes 0x0..0x9 map 1:1 onto register fields

  // Command opcodes (header byte bits [7:4])
  localparam logic [3:0] OP_MODE        = 4'h0;
  localparam logic [3:0] OP_SCALE       = 4'h1;
  localparam logic [3:0] OP_OFFSET_X    = 4'h2;
  localparam logic [3:0] OP_OFFSET_Y    = 4'h3;
  localparam logic [3:0] OP_TRANSP      = 4'h4;
  localparam logic [3:0] OP_CLIP_LEFT   = 4'h5;
  localparam logic [3:0] OP_CLIP_RIGHT  = 4'h6;
  localparam logic [3:0] OP_CLIP_TOP    = 4'h7;
  localparam logic [3:0] OP_CLIP_BOTTOM = 4'h8;
  localparam logic [3:0] OP_FREEZE      = 4'h9;
  localparam logic [3:0] OP_IMAGE       = 4'hA;
  localparam logic [3:0] OP_COMMIT      = 4'hB;

  // Overlay modes
  localparam logic [1:0] OVL_NONE   = 2'd0;
  localparam logic [1:0] OVL_CHROMA = 2'd1;
  localparam logic [1:0] OVL_DIRECT = 2'd2;

  // Command decoder FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PAYLOAD = 2'd1;
  localparam state_t ST_DISCARD = 2'd2;

  // Payload byte count per opcode; undefined opcodes report 0.
  function automatic logic [2:0] payload_len(input logic [3:0] op);
    logic [2:0] len;
    case (op)
      OP_MODE, OP_SCALE, OP_TRANSP, OP_FREEZE:            len = 3'd1;
      OP_OFFSET_X, OP_OFFSET_Y, OP_CLIP_LEFT, OP_CLIP_RIGHT,
      OP_CLIP_TOP, OP_CLIP_BOTTOM:                        len = 3'd2;
      OP_IMAGE:                                           len = 3'd6;
      default:                                            len = 3'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ctrl_layer_regs.sv
// One foreground layer's control register set.
//   clk, rst     : clock, asynchronous active-high reset
//   we, wdata    : per-field write enables (indexed by opcode) and right-aligned write data
//   commit       : copies staged values to the live outputs (shadowed build only)
//   overlay_mode .. fg_freeze : live field values
// Build option: LAYER_CTRL_SHADOW_EN adds a live bank behind the staging bank; without it the
// staging registers drive the outputs directly.
module ctrl_layer_regs
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned PRECISION              = 11,
  parameter int unsigned TRANSPARENCY_PRECISION = 3,
  parameter int unsigned DATA_W                 = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_FIELDS-1:0]             we,
  input  logic [DATA_W-1:0]                 wdata,
  input  logic                              commit,
  output logic [1:0]                        overlay_mode,
  output logic [1:0]                        fg_scale,
  output logic [PRECISION:0]                fg_offset_x,
  output logic [PRECISION:0]                fg_offset_y,
  output logic [TRANSPARENCY_PRECISION-1:0] fg_transparency,
  output logic [PRECISION-1:0]              fg_clip_left,
  output logic [PRECISION-1:0]              fg_clip_right,
  output logic [PRECISION-1:0]              fg_clip_top,
  output logic [PRECISION-1:0]              fg_clip_bottom,
  output logic                              fg_freeze
);

  localparam int unsigned SET_W = 4 + 2 * (PRECISION + 1) + TRANSPARENCY_PRECISION
                                  + 4 * PRECISION + 1;

  logic [1:0]                        mode_s, scale_s;
  logic [PRECISION:0]                offx_s, offy_s;
  logic [TRANSPARENCY_PRECISION-1:0] transp_s;
  logic [PRECISION-1:0]              cl_s, cr_s, ct_s, cb_s;
  logic                              freeze_s;
  logic [SET_W-1:0]                  staged, live;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_s   <= OVL_NONE;
      scale_s  <= '0;
      offx_s   <= '0;
      offy_s   <= '0;
      transp_s <= '0;
      cl_s     <= '0;
      cr_s     <= '0;
      ct_s     <= '0;
      cb_s     <= '0;
      freeze_s <= 1'b0;
    end else begin
      if (we[OP_MODE])        mode_s   <= wdata[1:0];
      if (we[OP_SCALE])       scale_s  <= wdata[1:0];
      if (we[OP_OFFSET_X])    offx_s   <= wdata[PRECISION:0];
      if (we[OP_OFFSET_Y])    offy_s   <= wdata[PRECISION:0];
      if (we[OP_TRANSP])      transp_s <= wdata[TRANSPARENCY_PRECISION-1:0];
      if (we[OP_CLIP_LEFT])   cl_s     <= wdata[PRECISION-1:0];
      if (we[OP_CLIP_RIGHT])  cr_s     <= wdata[PRECISION-1:0];
      if (we[OP_CLIP_TOP])    ct_s     <= wdata[PRECISION-1:0];
      if (we[OP_CLIP_BOTTOM]) cb_s     <= wdata[PRECISION-1:0];
      if (we[OP_FREEZE])      freeze_s <= wdata[0];
    end
  end

  assign staged = {freeze_s, cb_s, ct_s, cr_s, cl_s, transp_s, offy_s, offx_s, scale_s, mode_s};

`ifdef LAYER_CTRL_SHADOW_EN
  logic [SET_W-1:0] live_q;

  // Non-blocking copy means a write landing on the commit edge is held for the next commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q <= '0;
    end else if (commit) begin
      live_q <= staged;
    end
  end

  assign live = live_q;
`else
  logic unused_commit;
  assign unused_commit = commit;
  assign live          = staged;
`endif

  assign {fg_freeze, fg_clip_bottom, fg_clip_top, fg_clip_right, fg_clip_left, fg_transparency,
          fg_offset_y, fg_offset_x, fg_scale, overlay_mode} = live;

endmodule

// File: rtl/layer_control_bank.sv
// Byte-stream command decoder driving NUM_LAYERS foreground-layer control register sets and
// forwarding image-pixel writes.
//   clk, rst             : clock, asynchronous active-high reset
//   cmd_byte, cmd_valid  : command/payload byte stream, one byte per cycle, no backpressure
//   cmd_abort            : terminates any partial command (wins over cmd_valid)
//   frame_start          : frame boundary pulse, commits staged layer settings
//   ctrl_*               : per-layer live settings, layer 0 in the LSBs
//   ctrl_image_pixel*    : image write coordinates/value with a one-cycle ready strobe
//   err_count            : saturating protocol-error counter
// Build option: LAYER_CTRL_SHADOW_EN enables staging/commit; otherwise writes go straight live
// and frame_start / commit-now have no effect.
module layer_control_bank
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LAYERS             = 2,
  parameter int unsigned PRECISION              = 11,
  parameter int unsigned PIXEL_SIZE             = 16,
  parameter int unsigned RESOLUTION_X           = 800,
  parameter int unsigned RESOLUTION_Y           = 600,
  parameter int unsigned TRANSPARENCY_PRECISION = 3
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [7:0]                                   cmd_byte,
  input  logic                                         cmd_valid,
  input  logic                                         cmd_abort,
  input  logic                                         frame_start,
  output logic [2*NUM_LAYERS-1:0]                      ctrl_overlay_mode,
  output logic [2*NUM_LAYERS-1:0]                      ctrl_fg_scale,
  output logic [(PRECISION+1)*NUM_LAYERS-1:0]          ctrl_fg_offset_x,
  output logic [(PRECISION+1)*NUM_LAYERS-1:0]          ctrl_fg_offset_y,
  output logic [TRANSPARENCY_PRECISION*NUM_LAYERS-1:0] ctrl_fg_transparency,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_left,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_right,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_top,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_bottom,
  output logic [NUM_LAYERS-1:0]                        ctrl_fg_freeze,
  output logic [PRECISION-1:0]                         ctrl_image_pixel_x,
  output logic [PRECISION-1:0]                         ctrl_image_pixel_y,
  output logic [PIXEL_SIZE-1:0]                        ctrl_image_pixel,
  output logic                                         ctrl_image_pixel_ready,
  output logic [7:0]                                   err_count
);

  localparam int unsigned DATA_W = (PRECISION + 1 > TRANSPARENCY_PRECISION) ?
                                   PRECISION + 1 : TRANSPARENCY_PRECISION;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  layer_q, layer_d;
  // First five payload bytes; the sixth comes straight from cmd_byte to form the 48-bit word.
  logic [39:0] asm_q, asm_d;
  logic [7:0]  err_q;

  logic [PRECISION-1:0]  px_x_q, px_y_q;
  logic [PIXEL_SIZE-1:0] pix_q;
  logic                  ready_q;

  logic                  byte_ok, last_byte, is_reg_op, layer_ok, img_ok;
  logic                  reg_write, img_write, err_inc, commit_now, commit;
  logic [3:0]            hdr_op;
  logic [2:0]            hdr_len;
  logic [47:0]           word;
  logic [15:0]           img_x, img_y, img_pix;
  logic [NUM_FIELDS-1:0] field_we;

  assign byte_ok   = cmd_valid & ~cmd_abort;
  assign hdr_op    = cmd_byte[7:4];
  assign hdr_len   = payload_len(hdr_op);
  assign word      = {asm_q, cmd_byte};
  assign img_x     = word[47:32];
  assign img_y     = word[31:16];
  assign img_pix   = word[15:0];
  assign last_byte = (state_q == ST_PAYLOAD) && byte_ok && (cnt_q == 3'd1);
  assign is_reg_op = (op_q <= OP_FREEZE);
  assign layer_ok  = 32'(layer_q) < NUM_LAYERS;
  // Bounds are checked on the full 16-bit payload, before truncation to PRECISION.
  assign img_ok    = (32'(img_x) < RESOLUTION_X) && (32'(img_y) < RESOLUTION_Y);
  assign reg_write = last_byte && is_reg_op && layer_ok;
  assign img_write = last_byte && (op_q == OP_IMAGE) && img_ok;

  assign commit_now = (state_q == ST_IDLE) && byte_ok && (hdr_op == OP_COMMIT);
  assign commit     = frame_start | commit_now;

  always_comb begin
    field_we = '0;
    if (reg_write) field_we[op_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    layer_d = layer_q;
    asm_d   = asm_q;
    err_inc = 1'b0;
    if (cmd_abort) begin
      if (state_q == ST_PAYLOAD) err_inc = 1'b1;
      state_d = ST_IDLE;
    end else if (cmd_valid) begin
      case (state_q)
        ST_IDLE: begin
          op_d    = hdr_op;
          layer_d = cmd_byte[3:0];
          asm_d   = '0;  // keeps short payloads right-aligned with zero upper bits
          cnt_d   = hdr_len;
          if (hdr_op > OP_COMMIT) begin
            state_d = ST_DISCARD;
            err_inc = 1'b1;
          end else if (hdr_len != 3'd0) begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          asm_d = word[39:0];
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = ST_IDLE;
            if ((is_reg_op && !layer_ok) || ((op_q == OP_IMAGE) && !img_ok)) err_inc = 1'b1;
          end
        end
        ST_DISCARD: state_d = ST_DISCARD;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      layer_q <= '0;
      asm_q   <= '0;
      err_q   <= '0;
      px_x_q  <= '0;
      px_y_q  <= '0;
      pix_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      layer_q <= layer_d;
      asm_q   <= asm_d;
      if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
      ready_q <= img_write;
      if (img_write) begin
        px_x_q <= img_x[PRECISION-1:0];
        px_y_q <= img_y[PRECISION-1:0];
        pix_q  <= PIXEL_SIZE'(img_pix);
      end
    end
  end

  assign ctrl_image_pixel_x     = px_x_q;
  assign ctrl_image_pixel_y     = px_y_q;
  assign ctrl_image_pixel       = pix_q;
  assign ctrl_image_pixel_ready = ready_q;
  assign err_count              = err_q;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    logic [NUM_FIELDS-1:0] we;
    assign we = (layer_q == 4'(g)) ? field_we : '0;

    ctrl_layer_regs #(
      .PRECISION              (PRECISION),
      .TRANSPARENCY_PRECISION (TRANSPARENCY_PRECISION),
      .DATA_W                 (DATA_W)
    ) u_regs (
      .clk             (clk),
      .rst             (rst),
      .we              (we),
      .wdata           (word[DATA_W-1:0]),
      .commit          (commit),
      .overlay_mode    (ctrl_overlay_mode[g*2 +: 2]),
      .fg_scale        (ctrl_fg_scale[g*2 +: 2]),
      .fg_offset_x     (ctrl_fg_offset_x[g*(PRECISION+1) +: PRECISION+1]),
      .fg_offset_y     (ctrl_fg_offset_y[g*(PRECISION+1) +: PRECISION+1]),
      .fg_transparency (ctrl_fg_transparency[g*TRANSPARENCY_PRECISION +: TRANSPARENCY_PRECISION]),
      .fg_clip_left    (ctrl_fg_clip_left[g*PRECISION +: PRECISION]),
      .fg_clip_right   (ctrl_fg_clip_right[g*PRECISION +: PRECISION]),
      .fg_clip_top     (ctrl_fg_clip_top[g*PRECISION +: PRECISION]),
      .fg_clip_bottom  (ctrl_fg_clip_bottom[g*PRECISION +: PRECISION]),
      .fg_freeze       (ctrl_fg_freeze[g])
    );
  end

endmodule

// File: tb/tb_layer_control_bank.sv
// Self-checking bench for layer_control_bank (default parameters). Expectations follow the
// LAYER_CTRL_SHADOW_EN build option the same way the design does.
module tb_layer_control_bank;

  localparam int L  = 2;
  localparam int P  = 11;
  localparam int PS = 16;
  localparam int TP = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      cmd_byte;
  logic            cmd_valid;
  logic            cmd_abort;
  logic            frame_start;
  logic [2*L-1:0]  ctrl_overlay_mode;
  logic [2*L-1:0]  ctrl_fg_scale;
  logic [(P+1)*L-1:0] ctrl_fg_offset_x;
  logic [(P+1)*L-1:0] ctrl_fg_offset_y;
  logic [TP*L-1:0] ctrl_fg_transparency;
  logic [P*L-1:0]  ctrl_fg_clip_left;
  logic [P*L-1:0]  ctrl_fg_clip_right;
  logic [P*L-1:0]  ctrl_fg_clip_top;
  logic [P*L-1:0]  ctrl_fg_clip_bottom;
  logic [L-1:0]    ctrl_fg_freeze;
  logic [P-1:0]    ctrl_image_pixel_x;
  logic [P-1:0]    ctrl_image_pixel_y;
  logic [PS-1:0]   ctrl_image_pixel;
  logic            ctrl_image_pixel_ready;
  logic [7:0]      err_count;

  always #5 clk = ~clk;

  layer_control_bank #(
    .NUM_LAYERS             (L),
    .PRECISION              (P),
    .PIXEL_SIZE             (PS),
    .RESOLUTION_X           (800),
    .RESOLUTION_Y           (600),
    .TRANSPARENCY_PRECISION (TP)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .cmd_byte               (cmd_byte),
    .cmd_valid              (cmd_valid),
    .cmd_abort              (cmd_abort),
    .frame_start            (frame_start),
    .ctrl_overlay_mode      (ctrl_overlay_mode),
    .ctrl_fg_scale          (ctrl_fg_scale),
    .ctrl_fg_offset_x       (ctrl_fg_offset_x),
    .ctrl_fg_offset_y       (ctrl_fg_offset_y),
    .ctrl_fg_transparency   (ctrl_fg_transparency),
    .ctrl_fg_clip_left      (ctrl_fg_clip_left),
    .ctrl_fg_clip_right     (ctrl_fg_clip_right),
    .ctrl_fg_clip_top       (ctrl_fg_clip_top),
    .ctrl_fg_clip_bottom    (ctrl_fg_clip_bottom),
    .ctrl_fg_freeze         (ctrl_fg_freeze),
    .ctrl_image_pixel_x     (ctrl_image_pixel_x),
    .ctrl_image_pixel_y     (ctrl_image_pixel_y),
    .ctrl_image_pixel       (ctrl_image_pixel),
    .ctrl_image_pixel_ready (ctrl_image_pixel_ready),
    .err_count              (err_count)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] pix;
  } img_t;

  typedef struct {
    logic [7:0]  hdr;
    logic [47:0] pl;
    int          n;
    logic [15:0] exp;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  int          err_m    = 0;
  img_t        img_q[$];
  logic [15:0] live_m [10][L];
  logic [15:0] stage_m[10][L];
  vec_t        vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fmask(input int f);
    case (f)
      0, 1:       return 16'h0003;
      2, 3:       return 16'h0FFF;
      4:          return 16'h0007;
      5, 6, 7, 8: return 16'h07FF;
      default:    return 16'h0001;
    endcase
  endfunction

  function automatic logic [15:0] get_field(input int f, input int l);
    case (f)
      0:       return 16'(ctrl_overlay_mode[l*2 +: 2]);
      1:       return 16'(ctrl_fg_scale[l*2 +: 2]);
      2:       return 16'(ctrl_fg_offset_x[l*(P+1) +: P+1]);
      3:       return 16'(ctrl_fg_offset_y[l*(P+1) +: P+1]);
      4:       return 16'(ctrl_fg_transparency[l*TP +: TP]);
      5:       return 16'(ctrl_fg_clip_left[l*P +: P]);
      6:       return 16'(ctrl_fg_clip_right[l*P +: P]);
      7:       return 16'(ctrl_fg_clip_top[l*P +: P]);
      8:       return 16'(ctrl_fg_clip_bottom[l*P +: P]);
      default: return 16'(ctrl_fg_freeze[l]);
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int f = 0; f < 10; f++)
      for (int l = 0; l < L; l++)
        chk($sformatf("%s_f%0d_l%0d", tag, f, l), 32'(get_field(f, l)), 32'(live_m[f][l]));
  endtask

  task automatic model_commit();
`ifdef LAYER_CTRL_SHADOW_EN
    live_m = stage_m;
`endif
  endtask

  task automatic model_err();
    if (err_m < 255) err_m++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ab = 1'b0, input logic fs = 1'b0);
    @(negedge clk);
    cmd_byte    = b;
    cmd_valid   = 1'b1;
    cmd_abort   = ab;
    frame_start = fs;
    @(posedge clk);
    #1;
    cmd_valid   = 1'b0;
    cmd_abort   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    model_commit();
  endtask

  // Sends header plus n payload bytes (MSB first) and updates the model; fs raises
  // frame_start together with the last byte.
  task automatic send_raw(input logic [7:0] hdr, input logic [47:0] pl, input int n,
                          input logic fs);
    int op, layer;
    op    = int'(hdr[7:4]);
    layer = int'(hdr[3:0]);
    send_byte(hdr);
    for (int i = n - 1; i >= 0; i--) send_byte(pl[i*8 +: 8], 1'b0, (i == 0) ? fs : 1'b0);
    if (fs) model_commit();
    if (op <= 9) begin
      if (layer < L) begin
`ifdef LAYER_CTRL_SHADOW_EN
        stage_m[op][layer] = pl[15:0] & fmask(op);
`else
        live_m[op][layer] = pl[15:0] & fmask(op);
`endif
      end else begin
        model_err();
      end
    end else if (op == 10) begin
      if (pl[47:32] < 16'd800 && pl[31:16] < 16'd600)
        img_q.push_back({pl[42:32], pl[26:16], pl[15:0]});
      else
        model_err();
    end
  endtask

  // As send_raw, then checks the image strobe in cycle k+1 and that it lasts one cycle.
  task automatic send_cmd(input logic [7:0] hdr, input logic [47:0] pl, input int n,
                          input logic fs = 1'b0);
    img_t e;
    send_raw(hdr, pl, n, fs);
    if (img_q.size() != 0) begin
      e = img_q.pop_front();
      chk("img_ready", 32'(ctrl_image_pixel_ready), 32'd1);
      chk("img_x", 32'(ctrl_image_pixel_x), 32'(e.x));
      chk("img_y", 32'(ctrl_image_pixel_y), 32'(e.y));
      chk("img_pix", 32'(ctrl_image_pixel), 32'(e.pix));
      @(posedge clk);
      #1;
      chk("img_ready_one_cycle", 32'(ctrl_image_pixel_ready), 32'd0);
    end else begin
      chk("no_strobe", 32'(ctrl_image_pixel_ready), 32'd0);
    end
  endtask

  task automatic commit_and_check(input string tag);
`ifdef LAYER_CTRL_SHADOW_EN
    check_all({tag, "_pre"});
    pulse_fs();
`endif
    check_all(tag);
  endtask

  initial begin
    rst         = 1'b1;
    cmd_byte    = 8'h00;
    cmd_valid   = 1'b0;
    cmd_abort   = 1'b0;
    frame_start = 1'b0;
    for (int f = 0; f < 10; f++)
      for (int l = 0; l < L; l++) begin
        live_m[f][l]  = 16'h0;
        stage_m[f][l] = 16'h0;
      end

    vecs[0]  = '{8'h20, 48'h0FFF, 2, 16'h0FFF};
    vecs[1]  = '{8'h01, 48'h02,   1, 16'h0002};
    vecs[2]  = '{8'h11, 48'h07,   1, 16'h0003};
    vecs[3]  = '{8'h31, 48'h1234, 2, 16'h0234};
    vecs[4]  = '{8'h40, 48'hFD,   1, 16'h0005};
    vecs[5]  = '{8'h50, 48'h0123, 2, 16'h0123};
    vecs[6]  = '{8'h61, 48'hFFFF, 2, 16'h07FF};
    vecs[7]  = '{8'h70, 48'h0258, 2, 16'h0258};
    vecs[8]  = '{8'h81, 48'h012C, 2, 16'h012C};
    vecs[9]  = '{8'h91, 48'h03,   1, 16'h0001};
    vecs[10] = '{8'h00, 48'h01,   1, 16'h0001};

    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_ready", 32'(ctrl_image_pixel_ready), 32'd0);
    chk("reset_err", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      send_cmd(vecs[i].hdr, vecs[i].pl, vecs[i].n);
      commit_and_check($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_value", i),
          32'(get_field(int'(vecs[i].hdr[7:4]), int'(vecs[i].hdr[3:0]))), 32'(vecs[i].exp));
    end
    chk("layer1_mode_bits", 32'(ctrl_overlay_mode[3:2]), 32'd2);

    // Image writes: in-bounds corner, then x out of range.
    send_cmd(8'hA0, {16'd799, 16'd599, 16'hF800}, 6);
    chk("img_ok_err", 32'(err_count), 32'(err_m));
    send_cmd(8'hA3, {16'd800, 16'd599, 16'h1234}, 6);
    chk("img_oob_err", 32'(err_count), 32'd1);

    // Abort mid-payload (abort together with a valid byte), then a clean command.
    send_byte(8'h50);
    send_byte(8'h01);
    send_byte(8'h00, 1'b1);
    model_err();
    commit_and_check("abort");
    chk("abort_err", 32'(err_count), 32'(err_m));
    send_cmd(8'h50, 48'h0077, 2);
    commit_and_check("after_abort");
    chk("after_abort_clip", 32'(ctrl_fg_clip_left[P-1:0]), 32'h077);

    // Layer out of range.
    send_cmd(8'h05, 48'h12, 1);
    commit_and_check("bad_layer");
    chk("bad_layer_err", 32'(err_count), 32'(err_m));

    // Last byte coincident with frame_start.
    send_cmd(8'h40, 48'h02, 1, 1'b1);
    commit_and_check("coincident");
    chk("coincident_value", 32'(ctrl_fg_transparency[TP-1:0]), 32'd2);

    // Commit-now.
    send_cmd(8'h41, 48'h06, 1);
    send_byte(8'hB0);
    model_commit();
    check_all("commit_now");
    chk("commit_now_value", 32'(ctrl_fg_transparency[2*TP-1:TP]), 32'd6);

    // Back-to-back commands with no idle cycle between them.
    send_raw(8'h10, 48'h02, 1, 1'b0);
    send_raw(8'h21, 48'h0ABC, 2, 1'b0);
    send_raw(8'h60, 48'h0345, 2, 1'b0);
    commit_and_check("b2b");

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) send_cmd(8'h9F, 48'h01, 1);
    chk("err_saturate", 32'(err_count), 32'd255);

    // Undefined opcode swallows bytes until abort; the next command decodes normally.
    send_byte(8'hC0);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00, 1'b1);
    commit_and_check("discard");
    send_cmd(8'h00, 48'h02, 1);
    commit_and_check("after_discard");
    chk("after_discard_mode", 32'(ctrl_overlay_mode[1:0]), 32'd2);
    chk("final_err", 32'(err_count), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
